serial_link_top: RTL and testbench

// APB3-slave serial transmit/receive link controller, single clock domain. Software

---
 rtl/serial_link_top.sv | 258 +++++++++++++++++++++++++
 tb/tb_serial_link_top.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_top.sv
// APB3-controlled serial link: TX FIFO feeds a framed UART-style transmitter (header + COUNT
// data frames); the receiver (external or loopback line) fills an RX FIFO readable over APB.

module serial_link_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module serial_link_top #(
    parameter int ADDRESSWIDTH = 3,
    parameter int DATAWIDTH    = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [ADDRESSWIDTH-1:0] PADDR_i,
    input  logic [DATAWIDTH-1:0]    PWDATA_i,
    input  logic                    PWRITE_i,
    input  logic                    PSELx_i,
    input  logic                    PENABLE_i,
    output logic [DATAWIDTH-1:0]    PRDATA_o,
    output logic                    PREADY_o,
    input  logic                    rx_i,
    output logic                    tx_o,
    output logic                    busy_o
);
    localparam logic [ADDRESSWIDTH-1:0] A_STATUS   = ADDRESSWIDTH'(0);
    localparam logic [ADDRESSWIDTH-1:0] A_CTRL     = ADDRESSWIDTH'(1);
    localparam logic [ADDRESSWIDTH-1:0] A_DATA     = ADDRESSWIDTH'(2);
    localparam logic [ADDRESSWIDTH-1:0] A_HDR      = ADDRESSWIDTH'(3);
    localparam logic [ADDRESSWIDTH-1:0] A_COUNT    = ADDRESSWIDTH'(4);
    localparam logic [ADDRESSWIDTH-1:0] A_PRESCALE = ADDRESSWIDTH'(5);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} tx_state_t;

    logic [7:0]  ctrl, hdr;
    logic [15:0] count, prescale, bit_len, half;
    logic        done, tx_ovf, rx_ovf, underrun;
    logic        wr_acc, rd_acc, stat_rd, launch;
    logic        tx_push, tx_pop, tx_empty, tx_full;
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]  tx_rdata, rx_rdata;
    logic [8:0]  status;

    tx_state_t   state;
    logic [8:0]  tx_sh;
    logic [15:0] tx_cyc, remaining;
    logic [3:0]  tx_bit;
    logic        tx_active, bit_end, frame_last, done_set, underrun_set;

    logic        rx_s1, rx_s2, line, line_d, rx_act, rx_sample;
    logic [15:0] rx_off;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_sh;

    assign PREADY_o = 1'b1;
    assign wr_acc   = PSELx_i & PENABLE_i & PWRITE_i;
    assign rd_acc   = PSELx_i & PENABLE_i & ~PWRITE_i;
    assign stat_rd  = rd_acc && (PADDR_i == A_STATUS);
    assign tx_push  = wr_acc && (PADDR_i == A_DATA);
    assign rx_pop   = rd_acc && (PADDR_i == A_DATA);
    assign bit_len  = (prescale == 16'd0) ? 16'd1 : prescale;
    assign half     = bit_len >> 1;

    // New EN value counts, so a single 0x90 write from idle still launches.
    assign launch = wr_acc && (PADDR_i == A_CTRL) && PWDATA_i[4] && !ctrl[4] &&
                    PWDATA_i[7] && !busy_o;

    assign tx_active    = (state == S_HDR) || (state == S_DATA);
    assign bit_end      = tx_cyc >= bit_len - 16'd1;
    assign frame_last   = tx_active && ctrl[7] && bit_end && (tx_bit == 4'd9);
    assign tx_pop       = frame_last && (remaining != 16'd0) && !tx_empty;
    assign done_set     = frame_last && !tx_pop;
    assign underrun_set = frame_last && (remaining != 16'd0) && tx_empty;

    assign line      = ctrl[6] ? tx_o : rx_s2;
    assign rx_sample = rx_act && (rx_bit != 4'd0) && (rx_off == half);
    assign rx_push   = rx_sample && (rx_bit == 4'd9) && line;

    assign status = {underrun, rx_ovf, tx_ovf, done, rx_full, rx_empty, tx_full, tx_empty, busy_o};

    serial_link_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .push(tx_push), .pop(tx_pop),
        .wdata(PWDATA_i[7:0]), .rdata(tx_rdata), .empty(tx_empty), .full(tx_full)
    );

    serial_link_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .pop(rx_pop),
        .wdata(rx_sh), .rdata(rx_rdata), .empty(rx_empty), .full(rx_full)
    );

    always_comb begin
        PRDATA_o = '0;
        if (PSELx_i && !PWRITE_i) begin
            case (PADDR_i)
                A_STATUS:   PRDATA_o = DATAWIDTH'(status);
                A_CTRL:     PRDATA_o = DATAWIDTH'(ctrl);
                A_DATA:     PRDATA_o = rx_empty ? '0 : DATAWIDTH'(rx_rdata);
                A_HDR:      PRDATA_o = DATAWIDTH'(hdr);
                A_COUNT:    PRDATA_o = DATAWIDTH'(count);
                A_PRESCALE: PRDATA_o = DATAWIDTH'(prescale);
                default:    PRDATA_o = '0;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a STATUS read wins so no event is lost.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl     <= '0;
            hdr      <= '0;
            count    <= '0;
            prescale <= 16'd4;
            done     <= 1'b0;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_acc) begin
                case (PADDR_i)
                    A_CTRL:     ctrl     <= PWDATA_i[7:0];
                    A_HDR:      hdr      <= PWDATA_i[7:0];
                    A_COUNT:    count    <= PWDATA_i[15:0];
                    A_PRESCALE: prescale <= PWDATA_i[15:0];
                    default:    ;
                endcase
            end
            done     <= done_set | (done & ~stat_rd);
            tx_ovf   <= (tx_push & tx_full) | (tx_ovf & ~stat_rd);
            rx_ovf   <= (rx_push & rx_full) | (rx_ovf & ~stat_rd);
            underrun <= underrun_set | (underrun & ~stat_rd);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= S_IDLE;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            tx_sh     <= '1;
            tx_cyc    <= '0;
            tx_bit    <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (launch) begin
                        state     <= S_HDR;
                        busy_o    <= 1'b1;
                        tx_o      <= 1'b0;
                        tx_sh     <= {1'b1, hdr};
                        tx_cyc    <= '0;
                        tx_bit    <= '0;
                        remaining <= count;
                    end
                end
                default: begin
                    if (!ctrl[7]) begin
                        state  <= S_IDLE;
                        tx_o   <= 1'b1;
                        busy_o <= 1'b0;
                    end else if (bit_end) begin
                        tx_cyc <= '0;
                        if (tx_bit != 4'd9) begin
                            tx_o   <= tx_sh[0];
                            tx_sh  <= {1'b1, tx_sh[8:1]};
                            tx_bit <= tx_bit + 4'd1;
                        end else if (tx_pop) begin
                            state     <= S_DATA;
                            tx_o      <= 1'b0;
                            tx_sh     <= {1'b1, tx_rdata};
                            tx_bit    <= '0;
                            remaining <= remaining - 16'd1;
                        end else begin
                            state  <= S_DONE;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        tx_cyc <= tx_cyc + 16'd1;
                    end
                end
            endcase
        end
    end

    // Receiver: the falling-edge cycle is offset 0 of the start bit; the start bit itself is not re-checked.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1  <= 1'b1;
            rx_s2  <= 1'b1;
            line_d <= 1'b1;
            rx_act <= 1'b0;
            rx_off <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            rx_s1  <= rx_i;
            rx_s2  <= rx_s1;
            line_d <= line;
            if (!ctrl[5]) begin
                rx_act <= 1'b0;
            end else if (!rx_act) begin
                if (line_d && !line) begin
                    rx_act <= 1'b1;
                    rx_off <= (bit_len == 16'd1) ? 16'd0 : 16'd1;
                    rx_bit <= (bit_len == 16'd1) ? 4'd1 : 4'd0;
                end
            end else begin
                if (rx_sample) begin
                    if (rx_bit == 4'd9) rx_act <= 1'b0;
                    else                rx_sh  <= {line, rx_sh[7:1]};
                end
                if (rx_off >= bit_len - 16'd1) begin
                    rx_off <= '0;
                    rx_bit <= rx_bit + 4'd1;
                end else begin
                    rx_off <= rx_off + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_link_top.sv
// Directed bench for serial_link_top: a queue-based model predicts the tx_o/busy_o waveform,
// FIFO contents and STATUS; a negedge process compares the serial outputs every cycle.

module tb_serial_link_top;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [2:0]  PADDR = '0;
    logic [15:0] PWDATA = '0;
    logic        PWRITE = 1'b0, PSELx = 1'b0, PENABLE = 1'b0, rx_i = 1'b1;
    logic [15:0] PRDATA;
    logic        PREADY, tx_o, busy_o;

    always #5 PCLK = ~PCLK;

    serial_link_top dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR_i(PADDR), .PWDATA_i(PWDATA),
        .PWRITE_i(PWRITE), .PSELx_i(PSELx), .PENABLE_i(PENABLE), .PRDATA_o(PRDATA),
        .PREADY_o(PREADY), .rx_i(rx_i), .tx_o(tx_o), .busy_o(busy_o)
    );

    typedef struct packed { logic tx; logic busy; } samp_t;

    int          vecs = 0, errs = 0, busy_cnt = 0;
    samp_t       exp_q[$];
    logic [7:0]  txq[$], rxq[$];
    logic [7:0]  m_ctrl, m_hdr;
    logic [15:0] m_count, m_pre;
    logic        m_done, m_txovf, m_rxovf, m_under;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge PCLK) begin
        samp_t e;
        e.tx = 1'b1;
        e.busy = 1'b0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("tx_o", {31'd0, tx_o}, {31'd0, e.tx});
        chk("busy_o", {31'd0, busy_o}, {31'd0, e.busy});
        if (busy_o) busy_cnt++;
    end

    task automatic model_reset();
        exp_q.delete(); txq.delete(); rxq.delete();
        m_ctrl = 0; m_hdr = 0; m_count = 0; m_pre = 16'd4;
        m_done = 0; m_txovf = 0; m_rxovf = 0; m_under = 0;
    endtask

    // Whole transfer is predicted at launch: frame list, then one queue entry per PCLK cycle.
    task automatic launch(input logic lb);
        logic [7:0] fr[$];
        logic       bit_v;
        int         len;
        len = (m_pre == 16'd0) ? 1 : int'(m_pre);
        fr.push_back(m_hdr);
        for (int i = 0; i < int'(m_count); i++) begin
            if (txq.size() == 0) begin
                m_under = 1;
                break;
            end
            fr.push_back(txq.pop_front());
        end
        foreach (fr[k]) begin
            if (lb) begin
                if (rxq.size() < 16) rxq.push_back(fr[k]);
                else m_rxovf = 1;
            end
            for (int b = 0; b < 10; b++) begin
                bit_v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : fr[k][b-1];
                for (int c = 0; c < len; c++) exp_q.push_back(samp_t'({bit_v, 1'b1}));
            end
        end
    endtask

    task automatic model_write(input logic [2:0] a, input logic [15:0] d);
        samp_t keep;
        case (a)
            3'd1: begin
                if (d[4] && !m_ctrl[4] && d[7] && exp_q.size() == 0) launch(d[6] & d[5]);
                if (!d[7] && m_ctrl[7] && exp_q.size() > 0) begin
                    keep = exp_q[0];
                    exp_q.delete();
                    exp_q.push_back(keep);
                end
                m_ctrl = d[7:0];
            end
            3'd2: if (txq.size() < 16) txq.push_back(d[7:0]); else m_txovf = 1;
            3'd3: m_hdr = d[7:0];
            3'd4: m_count = d;
            3'd5: m_pre = d;
            default: ;
        endcase
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [15:0] d);
        @(posedge PCLK); #1;
        PSELx = 1; PWRITE = 1; PADDR = a; PWDATA = d; PENABLE = 0;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        PSELx = 0; PENABLE = 0; PWRITE = 0;
        model_write(a, d);
    endtask

    task automatic apb_read(input logic [2:0] a, output logic [15:0] d);
        @(posedge PCLK); #1;
        PSELx = 1; PWRITE = 0; PADDR = a; PENABLE = 0;
        @(posedge PCLK); #1;
        PENABLE = 1;
        #2;
        d = PRDATA;
        chk("pready", {31'd0, PREADY}, 32'd1);
        @(posedge PCLK); #1;
        PSELx = 0; PENABLE = 0;
    endtask

    task automatic rd_status(input string nm, output logic [15:0] d);
        logic [15:0] e;
        e = '0;
        e[0] = exp_q.size() != 0;
        e[1] = txq.size() == 0;
        e[2] = txq.size() == 16;
        e[3] = rxq.size() == 0;
        e[4] = rxq.size() == 16;
        e[5] = m_done; e[6] = m_txovf; e[7] = m_rxovf; e[8] = m_under;
        apb_read(3'd0, d);
        chk(nm, {16'd0, d}, {16'd0, e});
        m_done = 0; m_txovf = 0; m_rxovf = 0; m_under = 0;
    endtask

    task automatic rd_data(input string nm, output logic [15:0] d);
        logic [15:0] e;
        e = (rxq.size() > 0) ? {8'd0, rxq.pop_front()} : 16'd0;
        apb_read(3'd2, d);
        chk(nm, {16'd0, d}, {16'd0, e});
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge PCLK);
            n++;
        end
        chk(nm, exp_q.size(), 0);
        repeat (3) @(posedge PCLK);
        m_done = 1;
    endtask

    task automatic do_reset();
        @(posedge PCLK); #1;
        PRESETn = 0;
        model_reset();
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1;
    endtask

    initial begin
        logic [15:0] d;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1;
        chk("prdata_idle", {16'd0, PRDATA}, 0);
        chk("pready_rst", {31'd0, PREADY}, 1);
        chk("tx_rst", {31'd0, tx_o}, 1);
        rd_status("st_reset", d);      chk("st_reset_lit", {16'd0, d}, 32'h000A);
        apb_read(3'd5, d);             chk("prescale_rst", {16'd0, d}, 4);
        apb_read(3'd1, d);             chk("ctrl_rst", {16'd0, d}, 0);

        // TX FIFO overflow: 42 pushes, first 16 kept
        for (int i = 1; i <= 42; i++) apb_write(3'd2, 16'(i));
        rd_status("st_ovf", d);        chk("st_ovf_lit", {16'd0, d}, 32'h004C);
        rd_status("st_ovf_clr", d);    chk("st_ovf_clr_lit", {16'd0, d}, 32'h000C);

        // header 0x05 + one data frame, loopback
        apb_write(3'd3, 16'h05); apb_write(3'd4, 16'd1); apb_write(3'd1, 16'hE0);
        busy_cnt = 0;
        apb_write(3'd1, 16'hF0);
        wait_idle("xfer1_timeout");
        chk("busy_len1", busy_cnt, 80);
        apb_read(3'd1, d);             chk("ctrl_rb", {16'd0, d}, 32'h00F0);
        rd_status("st_done1", d);      chk("st_done1_lit", {16'd0, d}, 32'h0020);
        rd_data("rx1_0", d);           chk("rx1_0_lit", {16'd0, d}, 32'h05);
        rd_data("rx1_1", d);           chk("rx1_1_lit", {16'd0, d}, 32'h01);
        rd_data("rx_empty", d);        chk("rx_empty_lit", {16'd0, d}, 0);

        // header 0x58 + two frames, re-START while busy ignored
        apb_write(3'd1, 16'hE0); apb_write(3'd3, 16'h58); apb_write(3'd4, 16'd2);
        busy_cnt = 0;
        apb_write(3'd1, 16'hF0);
        repeat (10) @(posedge PCLK);
        apb_write(3'd1, 16'hE0); apb_write(3'd1, 16'hF0);
        wait_idle("xfer2_timeout");
        chk("busy_len2", busy_cnt, 120);
        rd_status("st_done2", d);      chk("st_done2_lit", {16'd0, d}, 32'h0020);
        rd_data("rx2_0", d);           chk("rx2_0_lit", {16'd0, d}, 32'h58);
        rd_data("rx2_1", d);           chk("rx2_1_lit", {16'd0, d}, 32'h02);
        rd_data("rx2_2", d);           chk("rx2_2_lit", {16'd0, d}, 32'h03);

        // underrun: COUNT 20 with 13 bytes queued
        apb_write(3'd1, 16'hE0); apb_write(3'd3, 16'hA5); apb_write(3'd4, 16'd20);
        busy_cnt = 0;
        apb_write(3'd1, 16'hF0);
        wait_idle("xfer3_timeout");
        chk("busy_len3", busy_cnt, 560);
        rd_status("st_under", d);      chk("st_under_lit", {16'd0, d}, 32'h0122);
        rd_data("rx3_hdr", d);         chk("rx3_hdr_lit", {16'd0, d}, 32'hA5);
        for (int i = 0; i < 12; i++) rd_data("rx3_mid", d);
        rd_data("rx3_last", d);        chk("rx3_last_lit", {16'd0, d}, 32'h10);

        // abort by clearing EN mid-frame
        for (int i = 0; i < 4; i++) apb_write(3'd2, 16'(8'h11 + i));
        apb_write(3'd1, 16'hE0); apb_write(3'd3, 16'h3C); apb_write(3'd4, 16'd4);
        apb_write(3'd1, 16'hF0);
        repeat (55) @(posedge PCLK);
        apb_write(3'd1, 16'h0060);
        repeat (4) @(posedge PCLK);
        chk("abort_tx", {31'd0, tx_o}, 1);
        apb_read(3'd0, d);             chk("abort_busy_done", {16'd0, d & 16'h0021}, 0);

        do_reset();
        rd_status("st_reset2", d);     chk("st_reset2_lit", {16'd0, d}, 32'h000A);

        // PRESCALE=0 gives 1-cycle bits
        apb_write(3'd5, 16'd0);
        apb_write(3'd2, 16'hC3); apb_write(3'd2, 16'h7E);
        apb_write(3'd3, 16'h81); apb_write(3'd4, 16'd2); apb_write(3'd1, 16'hE0);
        busy_cnt = 0;
        apb_write(3'd1, 16'hF0);
        wait_idle("xfer5_timeout");
        chk("busy_len5", busy_cnt, 30);
        rd_status("st_done5", d);      chk("st_done5_lit", {16'd0, d}, 32'h0022);
        rd_data("rx5_0", d);           chk("rx5_0_lit", {16'd0, d}, 32'h81);
        rd_data("rx5_1", d);           chk("rx5_1_lit", {16'd0, d}, 32'hC3);
        rd_data("rx5_2", d);           chk("rx5_2_lit", {16'd0, d}, 32'h7E);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
